lm_display_engine: RTL and testbench

- Parametrised LED manager front end. Pops display commands from the LED FIFO with a one-cycle-latency read handshake and drives the board LEDs.
- Successor to the plain LED decoder. Adds a minimum on-screen hold time per entry, blink mode, sticky accumulate mode (error latching), an explicit clear command and a selectable idle behaviour.
- Sits between the LM FIFO read port and the top-level LED pins.

---
 rtl/lm_display_engine.sv | 143 ++++++++++++++
 tb/tb_lm_display_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_display_engine.sv
// LED manager display engine: pops commands from the LED FIFO and drives the board LEDs,
// holding each entry on screen for a minimum time with static, blink, accumulate and clear modes.
module lm_display_engine #(
  parameter int unsigned WIDTH          = 10,
  parameter int unsigned HOLD_CYCLES    = 50000000,
  parameter int unsigned BLINK_HALF     = 12500000,
  parameter bit          CLEAR_ON_EMPTY = 1'b0,
  parameter int unsigned CNT_W          = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH+1:0] rd_data,
  input  logic             fifo_empty,
  output logic             rd_en,
  output logic [WIDTH-1:0] leds,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [1:0] ModeStatic = 2'b00;
  localparam logic [1:0] ModeBlink  = 2'b01;
  localparam logic [1:0] ModeAccum  = 2'b10;
  localparam logic [1:0] ModeClear  = 2'b11;

  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BlinkLast = CNT_W'(BLINK_HALF - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] leds_q, leds_d;

  logic [WIDTH-1:0] payload;
  logic [1:0]       cmd_mode;
  logic             hold_expire;

  assign payload     = rd_data[WIDTH-1:0];
  assign cmd_mode    = rd_data[WIDTH+1:WIDTH];
  assign hold_expire = (state_q == StHold) && (hold_cnt_q == HoldLast);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pattern_d   = pattern_q;
    mode_d      = mode_q;
    leds_d      = leds_q;
    rd_en       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          rd_en   = 1'b1;
          state_d = StWait;
        end
      end

      StWait: begin
        mode_d = cmd_mode;
        unique case (cmd_mode)
          ModeStatic: pattern_d = payload;
          ModeBlink:  pattern_d = payload;
          ModeAccum:  pattern_d = pattern_q | payload;
          ModeClear:  pattern_d = '0;
        endcase
        leds_d      = pattern_d;
        hold_cnt_d  = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        state_d     = StHold;
      end

      StHold: begin
        if (hold_expire) begin
          hold_cnt_d = '0;
          if (!fifo_empty) begin
            rd_en   = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StIdle;
            // A blinking entry freezes in its on phase when the FIFO runs dry.
            phase_d = 1'b1;
            if (CLEAR_ON_EMPTY) begin
              pattern_d = '0;
              leds_d    = '0;
            end else begin
              leds_d = pattern_q;
            end
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
          if (mode_q == ModeBlink) begin
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_d = '0;
              phase_d     = !phase_q;
              leds_d      = phase_d ? pattern_q : '0;
            end else begin
              blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Reset dominates: no pop may be issued while the engine is being reset.
    if (rst) begin
      rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      pattern_q   <= '0;
      mode_q      <= ModeStatic;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pattern_q   <= pattern_d;
      mode_q      <= mode_d;
      leds_q      <= leds_d;
    end
  end

  assign leds = leds_q;
  assign busy = (state_q == StWait) || (state_q == StHold);

endmodule

// File: tb/tb_lm_display_engine.sv
// Directed bench for lm_display_engine: three configurations fed from bench-side FIFO models,
// with a scoreboard of expected LED loads popped when each entry lands on the LEDs.
module tb_lm_display_engine;

  localparam int unsigned W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W+1:0] rd_data_a, rd_data_b, rd_data_c;
  logic         empty_a, empty_b, empty_c;
  logic         rd_en_a, rd_en_b, rd_en_c;
  logic [W-1:0] leds_a, leds_b, leds_c;
  logic         busy_a, busy_b, busy_c;

  logic [W+1:0] fq_a[$], fq_b[$], fq_c[$];
  logic [W-1:0] sb_a[$], sb_b[$], sb_c[$];
  bit           pend_a, pend_b, pend_c;
  bit           prev_a, prev_b, prev_c;
  int           total = 0;
  int           bad = 0;
  int           pulses_a = 0;

  lm_display_engine #(
    .WIDTH(W), .HOLD_CYCLES(4), .BLINK_HALF(2), .CLEAR_ON_EMPTY(1'b0), .CNT_W(26)
  ) dut_a (
    .clk(clk), .rst(rst), .rd_data(rd_data_a), .fifo_empty(empty_a),
    .rd_en(rd_en_a), .leds(leds_a), .busy(busy_a)
  );

  lm_display_engine #(
    .WIDTH(W), .HOLD_CYCLES(10), .BLINK_HALF(2), .CLEAR_ON_EMPTY(1'b0), .CNT_W(26)
  ) dut_b (
    .clk(clk), .rst(rst), .rd_data(rd_data_b), .fifo_empty(empty_b),
    .rd_en(rd_en_b), .leds(leds_b), .busy(busy_b)
  );

  lm_display_engine #(
    .WIDTH(W), .HOLD_CYCLES(4), .BLINK_HALF(2), .CLEAR_ON_EMPTY(1'b1), .CNT_W(26)
  ) dut_c (
    .clk(clk), .rst(rst), .rd_data(rd_data_c), .fifo_empty(empty_c),
    .rd_en(rd_en_c), .leds(leds_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample strobes mid-cycle, then model the FIFO and scoreboard just after the edge.
  task automatic tick();
    logic ea, eb, ec, rs;
    @(negedge clk);
    ea = rd_en_a;
    eb = rd_en_b;
    ec = rd_en_c;
    rs = rst;
    if (ea) begin
      check("rd_en_a_while_empty", {31'd0, empty_a}, 32'd0);
      check("rd_en_a_back_to_back", {31'd0, prev_a}, 32'd0);
      pulses_a++;
    end
    if (eb) begin
      check("rd_en_b_while_empty", {31'd0, empty_b}, 32'd0);
      check("rd_en_b_back_to_back", {31'd0, prev_b}, 32'd0);
    end
    if (ec) begin
      check("rd_en_c_while_empty", {31'd0, empty_c}, 32'd0);
      check("rd_en_c_back_to_back", {31'd0, prev_c}, 32'd0);
    end
    prev_a = ea;
    prev_b = eb;
    prev_c = ec;
    @(posedge clk);
    #1;
    if (rs) begin
      pend_a = 1'b0;
      pend_b = 1'b0;
      pend_c = 1'b0;
    end
    if (pend_a) begin
      pend_a = 1'b0;
      if (sb_a.size() > 0) check("load_a", leds_a, sb_a.pop_front());
      else check("load_a_unexpected", sb_a.size(), 1);
    end
    if (pend_b) begin
      pend_b = 1'b0;
      if (sb_b.size() > 0) check("load_b", leds_b, sb_b.pop_front());
      else check("load_b_unexpected", sb_b.size(), 1);
    end
    if (pend_c) begin
      pend_c = 1'b0;
      if (sb_c.size() > 0) check("load_c", leds_c, sb_c.pop_front());
      else check("load_c_unexpected", sb_c.size(), 1);
    end
    if (ea) begin
      if (fq_a.size() > 0) rd_data_a = fq_a.pop_front();
      pend_a = 1'b1;
    end
    if (eb) begin
      if (fq_b.size() > 0) rd_data_b = fq_b.pop_front();
      pend_b = 1'b1;
    end
    if (ec) begin
      if (fq_c.size() > 0) rd_data_c = fq_c.pop_front();
      pend_c = 1'b1;
    end
    empty_a = (fq_a.size() == 0);
    empty_b = (fq_b.size() == 0);
    empty_c = (fq_c.size() == 0);
  endtask

  function automatic int left(input int sel);
    case (sel)
      0:       return sb_a.size() + int'(pend_a);
      1:       return sb_b.size() + int'(pend_b);
      default: return sb_c.size() + int'(pend_c);
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Run until every expected load for one DUT has been observed.
  task automatic drain(input int sel, input int bound);
    int n = 0;
    while (left(sel) != 0 && n < bound) begin
      tick();
      n++;
    end
    check($sformatf("drain_%0d_timeout", sel), left(sel), 0);
  endtask

  task automatic wait_idle(input int sel, input int bound);
    int n = 0;
    while (busy_of(sel) && n < bound) begin
      tick();
      n++;
    end
    check($sformatf("idle_%0d_timeout", sel), {31'd0, busy_of(sel)}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] exp_led;
    rst = 1'b1;
    rd_data_a = '0;
    rd_data_b = '0;
    rd_data_c = '0;
    empty_b = 1'b1;
    empty_c = 1'b1;

    // Reset held with a non-empty FIFO: nothing may pop.
    fq_a.push_back({2'b00, 10'h155});
    fq_a.push_back({2'b00, 10'h2AA});
    sb_a.push_back(10'h155);
    sb_a.push_back(10'h2AA);
    empty_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_leds", leds_a, 0);
      check("reset_rd_en", {31'd0, rd_en_a}, 0);
      check("reset_busy", {31'd0, busy_a}, 0);
    end
    rst = 1'b0;
    #1;
    check("first_rd_en", {31'd0, rd_en_a}, 1);

    // Static sequence: each entry on screen HOLD_CYCLES+1 cycles when back to back.
    tick();
    check("wait_busy", {31'd0, busy_a}, 1);
    check("wait_rd_en", {31'd0, rd_en_a}, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("static_hold_155", leds_a, 10'h155);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check("static_busy_2aa", {31'd0, busy_a}, 1);
      tick();
    end
    check("static_idle_busy", {31'd0, busy_a}, 0);
    check("static_retained", leds_a, 10'h2AA);
    check("static_pulses", pulses_a, 2);
    tick();
    tick();
    check("static_still_retained", leds_a, 10'h2AA);

    // Accumulate then clear, from a fresh pattern.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("acc_reset_leds", leds_a, 0);
    fq_a.push_back({2'b10, 10'h001}); sb_a.push_back(10'h001);
    fq_a.push_back({2'b10, 10'h004}); sb_a.push_back(10'h005);
    fq_a.push_back({2'b10, 10'h200}); sb_a.push_back(10'h205);
    fq_a.push_back({2'b11, 10'h3FF}); sb_a.push_back(10'h000);
    empty_a = 1'b0;
    drain(0, 60);
    wait_idle(0, 20);
    check("acc_final", leds_a, 0);

    // Blink with half period 2 over a 10-cycle hold, then freeze on.
    fq_b.push_back({2'b01, 10'h0F0});
    sb_b.push_back(10'h0F0);
    empty_b = 1'b0;
    drain(1, 10);
    for (int i = 0; i < 10; i++) begin
      exp_led = (((i / 2) % 2) == 0) ? 10'h0F0 : 10'h000;
      check($sformatf("blink_%0d", i), leds_b, exp_led);
      tick();
    end
    check("blink_idle_busy", {31'd0, busy_b}, 0);
    check("blink_frozen_on", leds_b, 10'h0F0);
    repeat (3) tick();
    check("blink_frozen_later", leds_b, 10'h0F0);

    // Clear on empty: LEDs and busy drop together on the HOLD->IDLE edge.
    fq_c.push_back({2'b00, 10'h3C3});
    sb_c.push_back(10'h3C3);
    empty_c = 1'b0;
    drain(2, 10);
    for (int i = 0; i < 4; i++) begin
      check("coe_hold_leds", leds_c, 10'h3C3);
      check("coe_hold_busy", {31'd0, busy_c}, 1);
      tick();
    end
    check("coe_leds_cleared", leds_c, 0);
    check("coe_busy_fell", {31'd0, busy_c}, 0);

    // Reset mid-HOLD at count 2 with another word waiting.
    fq_a.push_back({2'b00, 10'h155});
    fq_a.push_back({2'b00, 10'h2AA});
    sb_a.push_back(10'h155);
    empty_a = 1'b0;
    drain(0, 10);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_leds", leds_a, 0);
    check("midrst_busy", {31'd0, busy_a}, 0);
    check("midrst_rd_en", {31'd0, rd_en_a}, 1);
    sb_a.push_back(10'h2AA);
    drain(0, 10);
    wait_idle(0, 20);
    check("midrst_final", leds_a, 10'h2AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
